// File: rtl/mod_div_seq.sv
// Multi-cycle unsigned DIV/MOD unit: restoring shift-subtract, one quotient bit per clock,
// MSB first, behind valid/ready handshakes on both the operand and the result side.
module mod_div_seq #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] number,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_num;
  logic [DATA_W-1:0] r_div;
  logic [DATA_W-1:0] r_rem;
  logic [CNT_W-1:0]  r_count;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_quotient;
  logic [DATA_W-1:0] r_remainder;
  logic              r_dbz;

  logic [DATA_W:0]   w_rem_shift;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_next;
  logic [DATA_W-1:0] w_num_next;
  logic              w_div_zero;
  logic              w_last;

  // r_num doubles as the quotient accumulator: dividend bits leave at the top as quotient bits enter
  assign w_rem_shift = {r_rem, r_num[DATA_W-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_div});
  assign w_rem_next  = w_ge ? DATA_W'(w_rem_shift - {1'b0, r_div}) : w_rem_shift[DATA_W-1:0];
  assign w_num_next  = {r_num[DATA_W-2:0], w_ge};
  assign w_div_zero  = (r_div == '0);
  assign w_last      = (r_count == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_next_state = S_CALC;
        S_CALC:  if (w_div_zero || w_last) w_next_state = S_DONE;
        S_DONE:  if (r_out_valid && out_ready) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) && enable;
    dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num       <= '0;
      r_div       <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (!enable) begin
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_num   <= number;
            r_div   <= divisor;
            r_rem   <= '0;
            r_count <= '0;
          end
        end
        S_CALC: begin
          // a zero divisor spends one cycle here so its result timing matches a single step
          if (w_div_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_num;
            r_dbz       <= 1'b1;
            r_out_valid <= 1'b1;
          end else begin
            r_rem   <= w_rem_next;
            r_num   <= w_num_next;
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
              r_quotient  <= w_num_next;
              r_remainder <= w_rem_next;
              r_dbz       <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mod_div_seq.sv
// Directed table plus corner-case sequences and a randomised sweep for mod_div_seq (DATA_W=8).
module tb_mod_div_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] number = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  mod_div_seq #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .number(number), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge with the unit idle. Accepts one operation, measures latency,
  // optionally stalls the result for 'hold' cycles, then hands it off.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                       input int elat, input logic rdy_early, input int hold);
    int k;
    number   = n;
    divisor  = d;
    in_valid = 1'b1;
    check("in_ready_before_accept", int'(in_ready), 1);
    tick();
    in_valid  = 1'b0;
    number    = W'($urandom_range(0, 255));
    divisor   = W'($urandom_range(0, 255));
    out_ready = rdy_early;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
      if (k < elat) check("in_ready_busy", int'(in_ready), 0);
    end
    check("latency", k, elat);
    check("quotient", int'(quotient), int'(eq));
    check("remainder", int'(remainder), int'(er));
    check("div_by_zero", int'(div_by_zero), int'(edbz));
    if (!rdy_early) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check("held_valid", int'(out_valid), 1);
        check("held_quotient", int'(quotient), int'(eq));
        check("held_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    check("valid_after_handoff", int'(out_valid), 0);
    check("in_ready_after_handoff", int'(in_ready), 1);
    check("quotient_kept", int'(quotient), int'(eq));
  endtask

  initial begin
    vecs[0]  = '{n: 8'd200, d: 8'd3,   q: 8'd66,  r: 8'd2,   dbz: 1'b0, lat: 8};
    vecs[1]  = '{n: 8'd7,   d: 8'd0,   q: 8'hFF,  r: 8'd7,   dbz: 1'b1, lat: 1};
    vecs[2]  = '{n: 8'd255, d: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0, lat: 8};
    vecs[3]  = '{n: 8'd0,   d: 8'd5,   q: 8'd0,   r: 8'd0,   dbz: 1'b0, lat: 8};
    vecs[4]  = '{n: 8'd9,   d: 8'd1,   q: 8'd9,   r: 8'd0,   dbz: 1'b0, lat: 8};
    vecs[5]  = '{n: 8'd150, d: 8'd4,   q: 8'd37,  r: 8'd2,   dbz: 1'b0, lat: 8};
    vecs[6]  = '{n: 8'd5,   d: 8'd9,   q: 8'd0,   r: 8'd5,   dbz: 1'b0, lat: 8};
    vecs[7]  = '{n: 8'd255, d: 8'd1,   q: 8'd255, r: 8'd0,   dbz: 1'b0, lat: 8};
    vecs[8]  = '{n: 8'd128, d: 8'd16,  q: 8'd8,   r: 8'd0,   dbz: 1'b0, lat: 8};
    vecs[9]  = '{n: 8'd254, d: 8'd255, q: 8'd0,   r: 8'd254, dbz: 1'b0, lat: 8};
    vecs[10] = '{n: 8'd0,   d: 8'd0,   q: 8'hFF,  r: 8'd0,   dbz: 1'b1, lat: 1};
    vecs[11] = '{n: 8'd129, d: 8'd128, q: 8'd1,   r: 8'd1,   dbz: 1'b0, lat: 8};

    // reset state
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat, 1'b0, 0);

    // backpressure: result held 5 cycles
    do_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, 1'b0, 5);

    // out_ready high while nothing is valid is ignored
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("ignored_out_ready_valid", int'(out_valid), 0);
    check("ignored_out_ready_in_ready", int'(in_ready), 1);

    // abort by enable low after step 3; outputs currently hold 100/7 result
    number = 8'd150; divisor = 8'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    enable = 1'b0;
    check("abort_in_ready_comb", int'(in_ready), 0);
    tick();
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_state_idle", int'(dbg_state), 0);
    tick(); tick();
    check("abort_in_ready_low", int'(in_ready), 0);
    check("abort_no_result", int'(out_valid), 0);
    enable = 1'b1;
    #1;
    check("enable_in_ready", int'(in_ready), 1);
    tick();

    // async reset mid-CALC: load a nonzero result first so the clear is visible
    do_op(8'd9, 8'd1, 8'd9, 8'd0, 1'b0, 8, 1'b0, 0);
    number = 8'd150; divisor = 8'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_quotient", int'(quotient), 0);
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_state", int'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    check("rst_mid_no_result", int'(out_valid), 0);
    do_op(8'd150, 8'd4, 8'd37, 8'd2, 1'b0, 8, 1'b0, 0);

    // randomised sweep with bench-computed expectations
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] rn, rd, eq, er;
      logic         early;
      int           hold;
      rn    = W'($urandom_range(0, 255));
      rd    = (i % 16 == 0) ? '0 : W'($urandom_range(0, 255));
      early = 1'($urandom_range(0, 1));
      hold  = $urandom_range(0, 3);
      if (rd == '0) begin
        eq = '1;
        er = rn;
      end else begin
        eq = rn / rd;
        er = rn % rd;
        n_checks++;
        if ((int'(eq) * int'(rd) + int'(er)) != int'(rn) || er >= rd) begin
          n_errors++;
          $display("FAIL model_invariant: n=%0d d=%0d q=%0d r=%0d", rn, rd, eq, er);
        end
      end
      do_op(rn, rd, eq, er, (rd == '0), (rd == '0) ? 1 : 8, early, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
